// File: rtl/uart_bus_arbiter_pkg.sv
// Shared types and helpers for the two-master cs/we/ack bus arbiter.
// Holds bus widths, master indices, FSM encoding and the round-robin pick rule.
package uart_bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // On a tie the master that did not win last time is chosen.
  function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end else if (req0) begin
      return M0;
    end else begin
      return M1;
    end
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_watchdog.sv
// Watchdog for a granted transfer: counts BUSY cycles, flags the cycle that reaches the limit.
// Latency: o_expired is combinational on the count; no backpressure, saturates at the limit.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module uart_bus_arbiter_watchdog
  import uart_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  // The counter holds completed BUSY cycles, so the Nth BUSY cycle sees N-1.
  localparam int unsigned     LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] LIMIT   = TO_W'(LIMIT_I);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_count && (cnt != LIMIT)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && i_count && (cnt == LIMIT);

endmodule

// File: rtl/uart_bus_arbiter.sv
// Two-master (UART=m0, CPU=m1) round-robin arbiter onto one cs/we/ack slave bus.
// Latency: request seen in IDLE -> o_cs next cycle; slave ack forwarded combinationally.
// Backpressure: grant held until ack, abort or watchdog; one TURN cycle drains the slave ack.
module uart_bus_arbiter
  import uart_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_cs,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_dat,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_dat,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_cs,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_dat,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_ack
);

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;
  logic   busy, sel_cs, wd_expired, timeout;

  // gnt doubles as the last-grant pointer; reset to m1 so m0 takes the first tie.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      gnt   <= M1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  assign busy   = (state == ST_BUSY);
  assign sel_cs = (gnt == M1) ? i_m1_cs : i_m0_cs;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_m0_cs || i_m1_cs) begin
          gnt_nxt   = pick_grant(i_m0_cs, i_m1_cs, gnt);
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack outranks a same-cycle timeout; an abort gets neither ack nor err.
        if (i_ack || !sel_cs) begin
          state_nxt = ST_TURN;
        end else if (wd_expired) begin
          state_nxt = ST_TURN;
          timeout   = 1'b1;
        end
      end
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  uart_bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (state == ST_IDLE),
    .i_count   (busy),
    .o_expired (wd_expired)
  );

  always_comb begin
    o_cs     = 1'b0;
    o_we     = 1'b0;
    o_addr   = '0;
    o_dat    = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m0_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    o_m1_dat = '0;
    if (busy) begin
      o_cs = sel_cs;
      if (gnt == M1) begin
        o_we     = i_m1_we;
        o_addr   = i_m1_addr;
        o_dat    = i_m1_dat;
        o_m1_ack = i_ack;
        o_m1_err = timeout;
        o_m1_dat = i_dat;
      end else begin
        o_we     = i_m0_we;
        o_addr   = i_m0_addr;
        o_dat    = i_m0_dat;
        o_m0_ack = i_ack;
        o_m0_err = timeout;
        o_m0_dat = i_dat;
      end
    end
  end

endmodule
